// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 32x32 byte-enabled register file: WB has priority, MD waits in a
// one-entry holding buffer, and a pending-destination scoreboard feeds the decode stall.
module rf_write_arbiter #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [4:0]    wb_dadd,
  input  logic [DW-1:0] wb_data,
  input  logic [1:0]    wb_size,
  input  logic [1:0]    wb_off,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_dadd,
  input  logic [DW-1:0] md_data,
  input  logic          iss_valid,
  input  logic [4:0]    iss_dadd,
  input  logic [4:0]    chk_add1,
  input  logic [4:0]    chk_add2,
  output logic          hazard1,
  output logic          hazard2,
  output logic          rf_wen,
  output logic [4:0]    rf_dadd,
  output logic [DW-1:0] rf_data,
  output logic          rf_wen_4,
  output logic          rf_wen_3,
  output logic          rf_wen_2,
  output logic          rf_wen_1,
  output logic          misalign
);

  logic            buf_full_q, buf_full_d;
  logic [4:0]      buf_dadd_q, buf_dadd_d;
  logic [DW-1:0]   buf_data_q, buf_data_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            wen_q, wen_d;
  logic [4:0]      dadd_q, dadd_d;
  logic [DW-1:0]   data_q, data_d;
  logic [3:0]      be_q, be_d;
  logic            misalign_q, misalign_d;
  logic            md_src_q, md_src_d;

  logic            md_hs;
  logic            wb_mis;
  logic [3:0]      wb_be;
  logic [DW-1:0]   wb_lane_data;

  assign md_ready = !rst && !buf_full_q;
  assign md_hs    = md_valid && md_ready;

  // Align sub-word WB data to its lanes and decide whether the access is legal.
  always_comb begin
    wb_mis       = 1'b0;
    wb_be        = 4'b0000;
    wb_lane_data = wb_data;
    unique case (wb_size)
      2'b00: begin
        wb_lane_data = {4{wb_data[7:0]}};
        wb_be        = 4'b0001 << wb_off;
      end
      2'b01: begin
        wb_lane_data = {2{wb_data[15:0]}};
        wb_mis       = wb_off[0];
        wb_be        = wb_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wb_mis = (wb_off != 2'b00);
        wb_be  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_dadd_d = buf_dadd_q;
    buf_data_d = buf_data_q;
    wen_d      = 1'b0;
    dadd_d     = 5'd0;
    data_d     = '0;
    be_d       = 4'b0000;
    misalign_d = 1'b0;
    md_src_d   = 1'b0;

    if (wb_valid) begin
      dadd_d     = wb_dadd;
      data_d     = wb_lane_data;
      misalign_d = wb_mis;
      wen_d      = !wb_mis && (wb_dadd != 5'd0);
      be_d       = wen_d ? wb_be : 4'b0000;
      // WB took the slot, so an MD handshake this cycle parks in the buffer.
      if (md_hs) begin
        buf_full_d = 1'b1;
        buf_dadd_d = md_dadd;
        buf_data_d = md_data;
      end
    end else if (buf_full_q) begin
      buf_full_d = 1'b0;
      dadd_d     = buf_dadd_q;
      data_d     = buf_data_q;
      wen_d      = (buf_dadd_q != 5'd0);
      be_d       = wen_d ? 4'b1111 : 4'b0000;
      md_src_d   = 1'b1;
    end else if (md_hs) begin
      dadd_d     = md_dadd;
      data_d     = md_data;
      wen_d      = (md_dadd != 5'd0);
      be_d       = wen_d ? 4'b1111 : 4'b0000;
      md_src_d   = 1'b1;
    end
  end

  // Clear lands on the same edge the register file commits; a same-edge issue wins.
  always_comb begin
    pending_d = pending_q;
    if (wen_q && md_src_q) pending_d[dadd_q] = 1'b0;
    if (iss_valid && (iss_dadd != 5'd0)) pending_d[iss_dadd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_dadd_q <= 5'd0;
      buf_data_q <= '0;
      pending_q  <= '0;
      wen_q      <= 1'b0;
      dadd_q     <= 5'd0;
      data_q     <= '0;
      be_q       <= 4'b0000;
      misalign_q <= 1'b0;
      md_src_q   <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_dadd_q <= buf_dadd_d;
      buf_data_q <= buf_data_d;
      pending_q  <= pending_d;
      wen_q      <= wen_d;
      dadd_q     <= dadd_d;
      data_q     <= data_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
      md_src_q   <= md_src_d;
    end
  end

  assign hazard1  = pending_q[chk_add1] && (chk_add1 != 5'd0);
  assign hazard2  = pending_q[chk_add2] && (chk_add2 != 5'd0);
  assign rf_wen   = wen_q;
  assign rf_dadd  = dadd_q;
  assign rf_data  = data_q;
  assign rf_wen_4 = be_q[3];
  assign rf_wen_3 = be_q[2];
  assign rf_wen_2 = be_q[1];
  assign rf_wen_1 = be_q[0];
  assign misalign = misalign_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: lane alignment, WB/MD priority, buffering, scoreboard.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_dadd;
  logic [31:0] wb_data;
  logic [1:0]  wb_size;
  logic [1:0]  wb_off;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_dadd;
  logic [31:0] md_data;
  logic        iss_valid;
  logic [4:0]  iss_dadd;
  logic [4:0]  chk_add1;
  logic [4:0]  chk_add2;
  logic        hazard1;
  logic        hazard2;
  logic        rf_wen;
  logic [4:0]  rf_dadd;
  logic [31:0] rf_data;
  logic        rf_wen_4;
  logic        rf_wen_3;
  logic        rf_wen_2;
  logic        rf_wen_1;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  // {wen, dadd, data, en4..en1, misalign}
  logic [42:0] out_vec;
  assign out_vec = {rf_wen, rf_dadd, rf_data, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign};

  rf_write_arbiter #(.NREG(32), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_dadd  (wb_dadd),
    .wb_data  (wb_data),
    .wb_size  (wb_size),
    .wb_off   (wb_off),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_dadd  (md_dadd),
    .md_data  (md_data),
    .iss_valid(iss_valid),
    .iss_dadd (iss_dadd),
    .chk_add1 (chk_add1),
    .chk_add2 (chk_add2),
    .hazard1  (hazard1),
    .hazard2  (hazard2),
    .rf_wen   (rf_wen),
    .rf_dadd  (rf_dadd),
    .rf_data  (rf_data),
    .rf_wen_4 (rf_wen_4),
    .rf_wen_3 (rf_wen_3),
    .rf_wen_2 (rf_wen_2),
    .rf_wen_1 (rf_wen_1),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_dadd = 0; wb_data = 0; wb_size = 0; wb_off = 0;
    md_valid = 0; md_dadd = 0; md_data = 0;
    iss_valid = 0; iss_dadd = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); chk_add1 = 0; chk_add2 = 0;
    tick(); tick();
    n_cmp++;
    if (out_vec !== 43'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=%h", out_vec, 43'd0);
    end
    n_cmp++;
    if (md_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_md_ready got=%b want=0", md_ready);
    end
    rst = 0; #1;
    n_cmp++;
    if (md_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_md_ready got=%b want=1", md_ready);
    end
  endtask

  task automatic test_word();
    wb_valid = 1; wb_dadd = 5; wb_data = 32'h12345678; wb_size = 2'b10; wb_off = 0;
    tick(); idle_inputs();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd5, 32'h12345678, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL wb_word got=%h want=%h", out_vec,
                        {1'b1, 5'd5, 32'h12345678, 4'b1111, 1'b0});
    end
    tick();
    n_cmp++;
    if (rf_wen !== 1'b0) begin
      n_err++; $display("FAIL wb_word_idle got=%b want=0", rf_wen);
    end
  endtask

  task automatic test_lanes();
    wb_valid = 1; wb_dadd = 6; wb_data = 32'h000000AB; wb_size = 2'b00; wb_off = 2;
    tick();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd6, 32'hABABABAB, 4'b0100, 1'b0}) begin
      n_err++; $display("FAIL wb_byte_off2 got=%h want=%h", out_vec,
                        {1'b1, 5'd6, 32'hABABABAB, 4'b0100, 1'b0});
    end
    wb_data = 32'h00000012; wb_off = 3;
    tick();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd6, 32'h12121212, 4'b1000, 1'b0}) begin
      n_err++; $display("FAIL wb_byte_off3 got=%h want=%h", out_vec,
                        {1'b1, 5'd6, 32'h12121212, 4'b1000, 1'b0});
    end
    wb_dadd = 8; wb_data = 32'h0000BEEF; wb_size = 2'b01; wb_off = 2;
    tick();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd8, 32'hBEEFBEEF, 4'b1100, 1'b0}) begin
      n_err++; $display("FAIL wb_half_off2 got=%h want=%h", out_vec,
                        {1'b1, 5'd8, 32'hBEEFBEEF, 4'b1100, 1'b0});
    end
    wb_data = 32'h00001234; wb_off = 0;
    tick(); idle_inputs();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd8, 32'h12341234, 4'b0011, 1'b0}) begin
      n_err++; $display("FAIL wb_half_off0 got=%h want=%h", out_vec,
                        {1'b1, 5'd8, 32'h12341234, 4'b0011, 1'b0});
    end
    tick();
  endtask

  task automatic test_misalign();
    // Park MD r6 in the buffer behind a WB word.
    wb_valid = 1; wb_dadd = 2; wb_data = 32'h0; wb_size = 2'b10; wb_off = 0;
    md_valid = 1; md_dadd = 6; md_data = 32'h66667777;
    tick();
    md_valid = 0;
    wb_dadd = 11; wb_data = 32'h0000BEEF; wb_size = 2'b01; wb_off = 1;
    tick(); wb_valid = 0; #0;
    n_cmp++;
    if ({rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign} !== 6'b000001) begin
      n_err++; $display("FAIL misalign_half got=%b want=000001",
                        {rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign});
    end
    n_cmp++;
    if (md_ready !== 1'b0) begin
      n_err++; $display("FAIL misalign_buf_held got=%b want=0", md_ready);
    end
    tick();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd6, 32'h66667777, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL misalign_buf_drain got=%h want=%h", out_vec,
                        {1'b1, 5'd6, 32'h66667777, 4'b1111, 1'b0});
    end
    wb_valid = 1; wb_dadd = 12; wb_size = 2'b10; wb_off = 2;
    tick(); idle_inputs();
    n_cmp++;
    if ({rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign} !== 6'b000001) begin
      n_err++; $display("FAIL misalign_word got=%b want=000001",
                        {rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign});
    end
    tick();
    n_cmp++;
    if (misalign !== 1'b0) begin
      n_err++; $display("FAIL misalign_pulse_end got=%b want=0", misalign);
    end
  endtask

  task automatic test_back_to_back();
    wb_valid = 1; wb_dadd = 3; wb_data = 32'h33333333; wb_size = 2'b10; wb_off = 0;
    md_valid = 1; md_dadd = 7; md_data = 32'hCAFEF00D;
    tick();
    wb_valid = 0;
    md_dadd = 8; md_data = 32'h11112222;
    #0;
    n_cmp++;
    if (out_vec !== {1'b1, 5'd3, 32'h33333333, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL b2b_wb_first got=%h want=%h", out_vec,
                        {1'b1, 5'd3, 32'h33333333, 4'b1111, 1'b0});
    end
    n_cmp++;
    if (md_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_md_ready_low got=%b want=0", md_ready);
    end
    tick();
    n_cmp++;
    if (out_vec !== {1'b1, 5'd7, 32'hCAFEF00D, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL b2b_md_r7 got=%h want=%h", out_vec,
                        {1'b1, 5'd7, 32'hCAFEF00D, 4'b1111, 1'b0});
    end
    n_cmp++;
    if (md_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_md_ready_back got=%b want=1", md_ready);
    end
    tick(); md_valid = 0;
    n_cmp++;
    if (out_vec !== {1'b1, 5'd8, 32'h11112222, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL b2b_md_r8 got=%h want=%h", out_vec,
                        {1'b1, 5'd8, 32'h11112222, 4'b1111, 1'b0});
    end
    tick();
    n_cmp++;
    if (rf_wen !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got=%b want=0", rf_wen);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_dadd = 9;
    tick(); iss_valid = 0;
    chk_add1 = 9; chk_add2 = 10; #0;
    n_cmp++;
    if ({hazard1, hazard2} !== 2'b10) begin
      n_err++; $display("FAIL sb_set got=%b want=10", {hazard1, hazard2});
    end
    tick(); tick();
    n_cmp++;
    if (hazard1 !== 1'b1) begin
      n_err++; $display("FAIL sb_hold got=%b want=1", hazard1);
    end
    md_valid = 1; md_dadd = 9; md_data = 32'h99999999;
    tick(); md_valid = 0; #0;
    n_cmp++;
    if ({rf_wen, rf_dadd, hazard1} !== {1'b1, 5'd9, 1'b1}) begin
      n_err++; $display("FAIL sb_on_rf got=%b want=%b", {rf_wen, rf_dadd, hazard1},
                        {1'b1, 5'd9, 1'b1});
    end
    tick();
    n_cmp++;
    if (hazard1 !== 1'b0) begin
      n_err++; $display("FAIL sb_cleared got=%b want=0", hazard1);
    end
    // Clear of r9 and re-issue of r9 on the same edge: the set must stick.
    iss_valid = 1; iss_dadd = 9;
    tick(); iss_valid = 0;
    md_valid = 1; md_dadd = 9; md_data = 32'h1;
    tick(); md_valid = 0;
    iss_valid = 1; iss_dadd = 9;
    tick(); iss_valid = 0;
    tick();
    n_cmp++;
    if (hazard1 !== 1'b1) begin
      n_err++; $display("FAIL sb_set_wins got=%b want=1", hazard1);
    end
    md_valid = 1; md_dadd = 9;
    tick(); md_valid = 0;
    tick();
    iss_valid = 1; iss_dadd = 0;
    tick(); iss_valid = 0;
    chk_add1 = 0; #0;
    n_cmp++;
    if ({hazard1, hazard2} !== 2'b00) begin
      n_err++; $display("FAIL sb_r0 got=%b want=00", {hazard1, hazard2});
    end
  endtask

  task automatic test_r0();
    md_valid = 1; md_dadd = 0; md_data = 32'hDEADBEEF;
    tick(); md_valid = 0; #0;
    n_cmp++;
    if ({rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1} !== 5'b00000) begin
      n_err++; $display("FAIL md_r0 got=%b want=00000",
                        {rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1});
    end
    n_cmp++;
    if (md_ready !== 1'b1) begin
      n_err++; $display("FAIL md_r0_consumed got=%b want=1", md_ready);
    end
    wb_valid = 1; wb_dadd = 0; wb_size = 2'b10; wb_off = 0; wb_data = 32'h5;
    tick(); idle_inputs();
    n_cmp++;
    if ({rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign} !== 6'b000000) begin
      n_err++; $display("FAIL wb_r0 got=%b want=000000",
                        {rf_wen, rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1, misalign});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1; iss_dadd = 4;
    tick(); iss_valid = 0;
    wb_valid = 1; wb_dadd = 1; wb_size = 2'b10; wb_off = 0; wb_data = 32'h1;
    md_valid = 1; md_dadd = 4; md_data = 32'h44444444;
    tick(); idle_inputs();
    chk_add1 = 4; #0;
    n_cmp++;
    if ({md_ready, hazard1} !== 2'b01) begin
      n_err++; $display("FAIL mid_pre_reset got=%b want=01", {md_ready, hazard1});
    end
    rst = 1; #1;
    n_cmp++;
    if (md_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_md_ready_rst got=%b want=0", md_ready);
    end
    tick();
    n_cmp++;
    if ({out_vec, hazard1} !== 44'd0) begin
      n_err++; $display("FAIL mid_reset_outputs got=%h want=0", {out_vec, hazard1});
    end
    rst = 0; #1;
    n_cmp++;
    if (md_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_md_ready_after got=%b want=1", md_ready);
    end
    tick();
    n_cmp++;
    if ({rf_wen, hazard1} !== 2'b00) begin
      n_err++; $display("FAIL mid_buf_discarded got=%b want=00", {rf_wen, hazard1});
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_back_to_back();
    test_scoreboard();
    test_r0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
